// File: rtl/spi_adc_sim_array_pkg.sv
// spi_adc_sim_array_pkg: shared constants for the simulated ADC SPI slave array.
package spi_adc_sim_array_pkg;
    localparam int SYNC_DEPTH = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    function automatic int frame_w(input int lead_zeros, input int data_w);
        return lead_zeros + data_w;
    endfunction
endpackage

// File: rtl/spi_adc_sim_channel.sv
// spi_adc_sim_channel: one simulated ADC SPI slave with a ramp/constant sample generator.
module spi_adc_sim_channel
    import spi_adc_sim_array_pkg::*;
#(
    parameter int                DATA_W     = 12,
    parameter int                LEAD_ZEROS = 4,
    parameter int                RAMP_STEP  = 1,
    parameter logic [DATA_W-1:0] SEED       = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ncs,
    input  logic              i_sclk,
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_const_val,
    output logic              o_dout,
    output logic              o_frame_done,
    output logic              o_short_frame
);
    localparam int FRAME_W = frame_w(LEAD_ZEROS, DATA_W);
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W - 1);

    // Each pipe holds SYNC_DEPTH synchroniser flops plus one history flop on top.
    logic [SYNC_DEPTH:0] r_ncs;
    logic [SYNC_DEPTH:0] r_sclk;
    logic [1:0]          r_state;
    logic [FRAME_W-1:0]  r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_ramp;
    logic                r_armed;
    logic                r_dout;
    logic                r_frame_done;
    logic                r_short_frame;
    logic                w_ncs_fall;
    logic                w_ncs_rise;
    logic                w_sclk_fall;
    logic [FRAME_W-1:0]  w_load;

    assign w_ncs_fall  = r_ncs[SYNC_DEPTH] & ~r_ncs[SYNC_DEPTH-1];
    assign w_ncs_rise  = ~r_ncs[SYNC_DEPTH] & r_ncs[SYNC_DEPTH-1];
    assign w_sclk_fall = r_sclk[SYNC_DEPTH] & ~r_sclk[SYNC_DEPTH-1];
    assign w_load      = FRAME_W'(i_mode ? i_const_val : r_ramp);

    assign o_dout        = r_dout;
    assign o_frame_done  = r_frame_done;
    assign o_short_frame = r_short_frame;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ncs         <= '0;
            r_sclk        <= '0;
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_ramp        <= SEED;
            r_armed       <= 1'b0;
            r_dout        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
        end else begin
            r_ncs         <= {r_ncs[SYNC_DEPTH-1:0], i_ncs};
            r_sclk        <= {r_sclk[SYNC_DEPTH-1:0], i_sclk};
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
            // Arming waits for a deselected bus so a frame cut by reset is never resumed.
            if (r_ncs[SYNC_DEPTH-1])
                r_armed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_dout <= 1'b0;
                    if (w_ncs_fall && r_armed)
                        r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_shift <= w_load;
                    r_dout  <= w_load[FRAME_W-1];
                    r_cnt   <= '0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_ncs_rise) begin
                        r_dout  <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (w_sclk_fall && r_cnt != CNT_MAX) begin
                        r_shift <= r_shift << 1;
                        r_cnt   <= r_cnt + 1'b1;
                        r_dout  <= r_shift[FRAME_W-2];
                    end
                end
                default: begin
                    r_dout <= 1'b0;
                    if (r_cnt >= CNT_FULL) begin
                        r_frame_done <= 1'b1;
                        r_ramp       <= r_ramp + DATA_W'(RAMP_STEP);
                    end else begin
                        r_short_frame <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/spi_adc_sim_array.sv
// spi_adc_sim_array: NUM_CH independent simulated ADC SPI slaves plus a debug SCLK divider.
module spi_adc_sim_array
    import spi_adc_sim_array_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 12,
    parameter int LEAD_ZEROS = 4,
    parameter int RAMP_STEP  = 1,
    parameter int DBG_DIV    = 5
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_ncs,
    input  logic [NUM_CH-1:0]        i_sclk,
    output logic [NUM_CH-1:0]        o_dout,
    input  logic [NUM_CH-1:0]        i_mode,
    input  logic [NUM_CH*DATA_W-1:0] i_const_val,
    output logic [NUM_CH-1:0]        o_frame_done,
    output logic [NUM_CH-1:0]        o_short_frame,
    output logic                     o_dbg_sclk
);
    logic [7:0] r_div;
    logic       r_dbg;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            spi_adc_sim_channel #(
                .DATA_W    (DATA_W),
                .LEAD_ZEROS(LEAD_ZEROS),
                .RAMP_STEP (RAMP_STEP),
                .SEED      (DATA_W'(i << (DATA_W - 1)))
            ) u_ch (
                .i_clk        (i_sys_clk),
                .i_rst        (i_rst),
                .i_ncs        (i_ncs[i]),
                .i_sclk       (i_sclk[i]),
                .i_mode       (i_mode[i]),
                .i_const_val  (i_const_val[i*DATA_W +: DATA_W]),
                .o_dout       (o_dout[i]),
                .o_frame_done (o_frame_done[i]),
                .o_short_frame(o_short_frame[i])
            );
        end
    endgenerate

    assign o_dbg_sclk = r_dbg;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_div <= '0;
            r_dbg <= 1'b0;
        end else if (r_div == 8'(DBG_DIV - 1)) begin
            r_div <= '0;
            r_dbg <= ~r_dbg;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end
endmodule

// File: tb/tb_spi_adc_sim_array.sv
// tb_spi_adc_sim_array: vector table, hand sequences and randomized frames against a sample model.
module tb_spi_adc_sim_array;
    localparam int NC   = 2;
    localparam int DW_A = 12;
    localparam int DW_B = 4;
    localparam int LZ   = 4;
    localparam int H    = 4;

    typedef struct {
        int inst;
        int ch;
        int n;
        int md;
        int cv;
        int exp_word;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NC-1:0] ncs_a = '1, sclk_a = '1, mode_a = '0;
    logic [NC-1:0] ncs_b = '1, sclk_b = '1, mode_b = '0;
    logic [NC*DW_A-1:0] cv_a = '0;
    logic [NC*DW_B-1:0] cv_b = '0;
    logic [NC-1:0] dout_a, fd_a, sf_a, dout_b, fd_b, sf_b;
    logic dbg_a, dbg_b;
    logic dbg_prev = 1'b0;
    bit   dbg_on = 1'b1;
    int tests = 0, fails = 0;
    int fd_cnt[2][NC];
    int sf_cnt[2][NC];
    int ramp[2][NC];
    int cyc = 0, toggles = 0, first_rise = 0, bad_toggle = 0;
    vec_t tbl[10];

    spi_adc_sim_array u_dut_a (
        .i_sys_clk(clk), .i_rst(rst), .i_ncs(ncs_a), .i_sclk(sclk_a), .o_dout(dout_a),
        .i_mode(mode_a), .i_const_val(cv_a), .o_frame_done(fd_a), .o_short_frame(sf_a),
        .o_dbg_sclk(dbg_a)
    );

    spi_adc_sim_array #(.DATA_W(DW_B)) u_dut_b (
        .i_sys_clk(clk), .i_rst(rst), .i_ncs(ncs_b), .i_sclk(sclk_b), .o_dout(dout_b),
        .i_mode(mode_b), .i_const_val(cv_b), .o_frame_done(fd_b), .o_short_frame(sf_b),
        .o_dbg_sclk(dbg_b)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            fd_cnt[0][c] += int'(fd_a[c]);
            sf_cnt[0][c] += int'(sf_a[c]);
            fd_cnt[1][c] += int'(fd_b[c]);
            sf_cnt[1][c] += int'(sf_b[c]);
        end
        if (dbg_on && !rst && cyc <= 100 && dbg_a !== dbg_prev) begin
            toggles++;
            if (dbg_a && first_rise == 0) first_rise = cyc;
            if (cyc % 5 != 0) bad_toggle++;
        end
        dbg_prev = dbg_a;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_pin(input int inst, input int ch, input bit is_sclk, input logic v);
        if (inst == 0) begin
            if (is_sclk) sclk_a[ch] = v; else ncs_a[ch] = v;
        end else begin
            if (is_sclk) sclk_b[ch] = v; else ncs_b[ch] = v;
        end
    endtask

    function automatic int dout_of(input int inst, input int ch);
        return int'(inst == 0 ? dout_a[ch] : dout_b[ch]);
    endfunction

    task automatic set_src(input int inst, input int ch, input int md, input int cv);
        if (inst == 0) begin
            mode_a[ch] = md[0];
            cv_a[ch*DW_A +: DW_A] = DW_A'(cv);
        end else begin
            mode_b[ch] = md[0];
            cv_b[ch*DW_B +: DW_B] = DW_B'(cv);
        end
    endtask

    function automatic int dw_of(input int inst);
        return inst == 0 ? DW_A : DW_B;
    endfunction

    task automatic reset_model();
        for (int c = 0; c < NC; c++) begin
            ramp[0][c] = (c << (DW_A - 1)) % (1 << DW_A);
            ramp[1][c] = (c << (DW_B - 1)) % (1 << DW_B);
        end
    endtask

    // Drives one frame of n falling SCLK edges and reassembles the bits seen on DOUT.
    task automatic frame(input int inst, input int ch, input int n, output int got);
        int fw;
        fw = dw_of(inst) + LZ;
        set_pin(inst, ch, 0, 1'b0);
        wait_cyc(8);
        got = dout_of(inst, ch) << (fw - 1);
        for (int e = 1; e <= n; e++) begin
            set_pin(inst, ch, 1, 1'b0);
            wait_cyc(H);
            set_pin(inst, ch, 1, 1'b1);
            wait_cyc(H);
            if (e < fw) got |= dout_of(inst, ch) << (fw - 1 - e);
            else chk("dout after last bit", dout_of(inst, ch), 0);
        end
        set_pin(inst, ch, 0, 1'b1);
        wait_cyc(8);
    endtask

    task automatic do_frame(input int inst, input int ch, input int n, input int md,
                            input int cv, input int exp_word);
        int fw, nb, mask, got, fd0, sf0, full;
        fw = dw_of(inst) + LZ;
        full = (n >= fw - 1) ? 1 : 0;
        set_src(inst, ch, md, cv);
        fd0 = fd_cnt[inst][ch];
        sf0 = sf_cnt[inst][ch];
        frame(inst, ch, n, got);
        nb = (n + 1 < fw) ? n + 1 : fw;
        mask = ((1 << nb) - 1) << (fw - nb);
        chk($sformatf("data i%0d ch%0d n%0d", inst, ch, n), got & mask, exp_word & mask);
        chk($sformatf("frame_done i%0d ch%0d", inst, ch), fd_cnt[inst][ch] - fd0, full);
        chk($sformatf("short_frame i%0d ch%0d", inst, ch), sf_cnt[inst][ch] - sf0, 1 - full);
        if (full == 1) ramp[inst][ch] = (ramp[inst][ch] + 1) % (1 << dw_of(inst));
    endtask

    task automatic model_frame(input int inst, input int ch, input int n, input int md, input int cv);
        int smp;
        smp = (md != 0) ? cv % (1 << dw_of(inst)) : ramp[inst][ch];
        do_frame(inst, ch, n, md, cv, smp);
    endtask

    initial begin
        int fd0, sf0, inst, ch, fw, n;
        tbl[0] = '{0, 0, 16, 0, 0,     'h000};
        tbl[1] = '{0, 0, 16, 0, 0,     'h001};
        tbl[2] = '{0, 1, 16, 1, 'hA5C, 'hA5C};
        tbl[3] = '{0, 1, 16, 0, 0,     'h801};
        tbl[4] = '{0, 0, 8,  0, 0,     'h002};
        tbl[5] = '{0, 0, 16, 0, 0,     'h002};
        tbl[6] = '{0, 0, 16, 1, 'hFFF, 'hFFF};
        tbl[7] = '{0, 0, 15, 0, 0,     'h004};
        tbl[8] = '{0, 0, 14, 0, 0,     'h005};
        tbl[9] = '{0, 0, 16, 0, 0,     'h005};
        reset_model();

        wait_cyc(3);
        chk("reset dout", int'(dout_a), 0);
        chk("reset frame_done", int'(fd_a), 0);
        chk("reset short_frame", int'(sf_a), 0);
        chk("reset dbg_sclk", int'(dbg_a), 0);
        rst = 1'b0;
        wait_cyc(102);
        chk("dbg first rise cycle", first_rise, 5);
        chk("dbg toggles in 100 cycles", toggles, 20);
        chk("dbg off-grid toggles", bad_toggle, 0);
        dbg_on = 1'b0;

        for (int k = 0; k < 10; k++)
            do_frame(tbl[k].inst, tbl[k].ch, tbl[k].n, tbl[k].md, tbl[k].cv, tbl[k].exp_word);

        // Narrow instance: walk ch0 through the whole ramp range and across the wrap.
        for (int k = 0; k < 17; k++) model_frame(1, 0, 8, 0, 0);
        model_frame(1, 1, 8, 0, 0);

        // nCS rise coincident with the 15th SCLK fall: the SCLK edge must be dropped.
        fd0 = fd_cnt[0][0];
        sf0 = sf_cnt[0][0];
        set_src(0, 0, 0, 0);
        set_pin(0, 0, 0, 1'b0);
        wait_cyc(8);
        for (int e = 0; e < 14; e++) begin
            set_pin(0, 0, 1, 1'b0);
            wait_cyc(H);
            set_pin(0, 0, 1, 1'b1);
            wait_cyc(H);
        end
        set_pin(0, 0, 1, 1'b0);
        set_pin(0, 0, 0, 1'b1);
        wait_cyc(H);
        set_pin(0, 0, 1, 1'b1);
        wait_cyc(8);
        chk("same-cycle short_frame", sf_cnt[0][0] - sf0, 1);
        chk("same-cycle frame_done", fd_cnt[0][0] - fd0, 0);
        model_frame(0, 0, 16, 0, 0);

        for (int k = 0; k < 30; k++) begin
            inst = $urandom_range(0, 1);
            ch = $urandom_range(0, NC - 1);
            fw = dw_of(inst) + LZ;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, fw - 2) : $urandom_range(fw - 1, fw);
            model_frame(inst, ch, n, $urandom_range(0, 1), $urandom_range(0, 4095));
        end

        // Reset in the middle of a frame with nCS held low.
        set_src(0, 0, 1, 'hFFF);
        set_pin(0, 0, 0, 1'b0);
        wait_cyc(8);
        for (int e = 0; e < 6; e++) begin
            set_pin(0, 0, 1, 1'b0);
            wait_cyc(H);
            set_pin(0, 0, 1, 1'b1);
            wait_cyc(H);
        end
        chk("dout before reset", dout_of(0, 0), 1);
        rst = 1'b1;
        wait_cyc(1);
        chk("dout after reset", dout_of(0, 0), 0);
        rst = 1'b0;
        reset_model();
        fd0 = fd_cnt[0][0];
        sf0 = sf_cnt[0][0];
        for (int e = 0; e < 4; e++) begin
            set_pin(0, 0, 1, 1'b0);
            wait_cyc(H);
            set_pin(0, 0, 1, 1'b1);
            wait_cyc(H);
            chk("dout disarmed", dout_of(0, 0), 0);
        end
        set_pin(0, 0, 0, 1'b1);
        wait_cyc(8);
        chk("no frame_done after reset", fd_cnt[0][0] - fd0, 0);
        chk("no short_frame after reset", sf_cnt[0][0] - sf0, 0);
        model_frame(0, 0, 16, 0, 0);
        model_frame(0, 1, 16, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_adc_sim_array.md
Name: spi_adc_sim_array

Overview:
- Parametrised multi-channel simulated-ADC SPI slave array used to exercise the SPI master before real ADCs are fitted.
- Each channel serves fixed-length frames of configurable width from an internal sample generator: ramp or constant.
- SPI inputs are synchronised to and oversampled by sys_clk.
- A programmable debug SCLK is generated on-chip and can be jumpered in place of the master clock.

Parameters:
- NUM_CH, 2, number of independent SPI slave channels.
- DATA_W, 12, sample width in bits.
- LEAD_ZEROS, 4, zero bits sent before the sample MSB; FRAME_W = LEAD_ZEROS + DATA_W (16).
- RAMP_STEP, 1, per-frame sample increment in ramp mode.
- DBG_DIV, 5, sys_clk cycles per dbg_sclk half-period; legal range 2..255.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- nCS  in  NUM_CH  per-channel chip select, active-low, asynchronous to sys_clk.
- SCLK  in  NUM_CH  per-channel SPI clock, asynchronous to sys_clk.
- DOUT  out  NUM_CH  per-channel serial data, MSB first.
- mode  in  NUM_CH  per channel: 0 = ramp, 1 = constant.
- const_val  in  NUM_CH*DATA_W  constant sample per channel; channel i occupies bits [i*DATA_W +: DATA_W].
- frame_done  out  NUM_CH  one-cycle pulse when a complete frame ends.
- short_frame  out  NUM_CH  one-cycle pulse when nCS rises before FRAME_W falling SCLK edges.
- dbg_sclk  out  1  divided debug clock.

Behaviour:
- Reset values: DOUT=0, frame_done=0, short_frame=0, dbg_sclk=0, bit counters=0, divider=0.
- Reset ramp seed: channel i starts at i << (DATA_W-1), truncated to DATA_W bits.
- Input sync: nCS and SCLK each pass through a 2-flop synchroniser plus one history flop; edges are detected on the synchronised pair.
- Input timing: pin-to-DOUT latency is 3 sys_clk cycles. Legal SCLK high and low times are each >= 4 sys_clk cycles.
- Channel states:
  - IDLE -> LOAD on an nCS falling edge, only while armed.
  - LOAD, 1 cycle: shift register <= {LEAD_ZEROS zeros, sample}, where sample = const_val slice if mode=1, else the ramp value; mode is sampled here. DOUT <= shift register MSB. Bit counter <= 0. -> SHIFT.
  - SHIFT: each SCLK falling edge shifts left and increments the bit counter. DOUT shows the new MSB; after FRAME_W edges DOUT=0 and further edges are ignored.
  - SHIFT -> DONE on an nCS rising edge.
  - DONE, 1 cycle:
    - if bit counter >= FRAME_W-1 (full frame): pulse frame_done and advance ramp by RAMP_STEP, wrapping modulo 2^DATA_W;
    - otherwise pulse short_frame and leave ramp unchanged;
    - then -> IDLE.
- The ramp advances even when mode=1.
- DOUT is 0 whenever the channel is not in LOAD or SHIFT.
- Same-cycle nCS rising edge and SCLK falling edge: the nCS edge wins and the SCLK edge is discarded.
- Reset mid-frame: everything returns to reset values and the channel is disarmed. It re-arms only after synchronised nCS is seen high, so no partial frame is resumed.
- Armed after reset is cleared and nCS has been high for >= 1 cycle.
- Channels are fully independent and share only sys_clk, rst and the generator parameters.
- Debug divider: 8-bit counter increments each cycle. On reaching DBG_DIV-1 it clears and toggles dbg_sclk, giving a period of 2*DBG_DIV cycles (default 10 cycles = 5 MHz).

Decomposition:
- Shared package/header: FRAME_W derivation, channel state encodings (IDLE, LOAD, SHIFT, DONE), synchroniser depth constant.
- Sub-module spi_adc_sim_channel: synchroniser, FSM, shift register and ramp. Instantiated NUM_CH times via generate.
- The debug divider stays in the top level.

Test Plan:
- Reset release, ch0 ramp, one full 16-edge frame at 4-cycle half-periods -> DOUT bits 0x0000. frame_done pulses once. Next frame reads 0x0001.
- ch1 with mode=1, const_val=0xA5C -> frame 0x0A5C (four leading zeros, then 1010_0101_1100); ramp on ch1 still advances 0x800 -> 0x801.
- ch0 ramp preloaded near the top via 4095 frames -> frame reads 0x0FFF, and the next frame reads 0x0000 (wrap).
- nCS raised after 8 SCLK falling edges -> short_frame pulses, frame_done stays 0, next frame repeats the same sample value.
- rst asserted at bit 6 of a frame with nCS held low -> DOUT=0 next cycle. SCLK edges ignored until nCS goes high then low. New frame starts from the seed value.
- Free-running check over 100 cycles after reset -> dbg_sclk toggles every 5 cycles, first rising edge at cycle 5.
